score_bcd_converter: RTL and testbench
======================================

# score_bcd_converter

Sequential binary-to-BCD converter that feeds the on-screen score. It takes the 14-bit binary score from the score register and produces four BCD digits (thousands to ones) for the digit renderer. It uses a shift-and-add-3 (double-dabble) state machine: one bit per clock, with a start/ready/done handshake. The four digit outputs update together, in one clock, at the end of a conversion, so the renderer never sees a partially converted value.

## Interface
- `MAX_VALUE`, default 9999: clamp ceiling applied to the input at load. It must be ≤ 9999.
- `clk` input, 1 bit: system clock. All state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: conversion request. Sampled only while `ready` = 1.
- `in` input, 14 bits: unsigned binary value. Sampled only on the edge that accepts `start`.
- `ready` output, 1 bit: high when idle and able to accept `start`.
- `done_tick` output, 1 bit: registered one-cycle pulse. It is high in the cycle in which new digits first appear.
- `bcd3` output, 4 bits: thousands digit.
- `bcd2` output, 4 bits: hundreds digit.
- `bcd1` output, 4 bits: tens digit.
- `bcd0` output, 4 bits: ones digit.

## Operation
- **States:** IDLE and OP. State changes only on rising edges of `clk`.
- **Internal registers:**
  - `bin_work`: 14 bits.
  - `bcd_work`: 16 bits.
  - `n`: 4-bit iteration counter.
  - Output registers: `bcd3`–`bcd0` and `done_tick`.
- **IDLE:** `ready` = 1.
  - On an edge with `start` = 1:
    - `bin_work` ← min(`in`, `MAX_VALUE`).
    - `bcd_work` ← 0.
    - `n` ← 14.
    - State → OP.
  - On an edge with `start` = 0: no change.
- **OP:** `ready` = 0. On each edge, perform one iteration:
  - Adjust: each 4-bit digit of `bcd_work` that is ≥ 5 gets +3. All four digits are adjusted in parallel, and the adjustment never carries into the next digit.
  - Shift: `{bcd_work, bin_work}` ← `{adjusted_bcd, bin_work}` shifted left by 1. The MSB of `bin_work` enters the LSB of `bcd_work`.
  - Decrement: `n` ← `n` − 1.
  - On the iteration where `n` = 1 (the 14th):
    - The post-shift value is written directly into `bcd3..bcd0`.
    - `done_tick` ← 1.
    - State → IDLE.
- **`start` while in OP:** ignored. There is no queuing and `in` is not resampled.
- **Outputs between conversions:** `bcd3..bcd0` hold the last completed result until the next conversion finishes. `bcd_work` is never visible on the outputs.
- **`done_tick`:** cleared on every edge on which it is not set.
- **Reset (asynchronous, any state, including mid-OP):**
  - State → IDLE.
  - `bin_work`, `bcd_work`, `n` → 0.
  - `bcd3..bcd0` → 0.
  - `done_tick` → 0.
  - Any conversion in progress is discarded. `ready` = 1 immediately.
- **Width rules:** each digit stays in 0–9 at every step. The clamp guarantees the result fits in 4 digits.

## Timing
- **Reset values:**
  - `ready` = 1.
  - `done_tick` = 0.
  - `bcd3`, `bcd2`, `bcd1`, `bcd0` = 0.
- **Latency:** `start` accepted at edge k → 14 OP iterations on edges k+1 … k+14.
  - New digits are valid after edge k+14.
  - `done_tick` = 1 for exactly the cycle between edges k+14 and k+15.
  - `ready` = 1 again after edge k+14.
- **Throughput:**
  - `start` high on edge k+14 is ignored, because the state is still OP on that edge.
  - The earliest next acceptance is edge k+15.
  - Minimum start-to-start interval is therefore 15 cycles.
- **`ready` timing:** combinational from state (`ready` = 1 when state = IDLE), with no extra latency. `done_tick` and `ready` are both high in the cycle after completion.
- **Caller requirement:** `in` needs to be stable only on the accepting edge. The score logic may change it freely afterwards.

## Test plan
- Reset check: assert `reset` asynchronously with no clock running → `ready` = 1, `done_tick` = 0, all digits 0.
- Normal conversions, each with `start` held high for one edge:
  - `in` = 9990 → after 14 more edges, digits = 9, 9, 9, 0. `done_tick` is high for exactly one cycle; `ready` has returned to 1.
  - `in` = 0 → digits = 0, 0, 0, 0 with `done_tick` pulsed.
  - `in` = 1234 → digits = 1, 2, 3, 4.
- Clamp: `in` = 16383 → digits = 9, 9, 9, 9. Repeat with `MAX_VALUE` = 5000 and `in` = 6000 → digits = 5, 0, 0, 0.
- Busy handling:
  - Convert 10. While in OP, pulse `start` with `in` = 20 → result is 0, 0, 1, 0, and only one `done_tick` occurs.
  - During conversion of 20, the digits still read 0010 until completion.
- Back-to-back: `start` held high continuously, `in` = 40 → a `done_tick` every 15 cycles, digits = 0, 0, 4, 0.
- Mid-operation reset: start converting 9999, assert `reset` after 7 edges → digits = 0, `ready` = 1, and no `done_tick` afterwards. A following conversion of 50 yields 0, 0, 5, 0.

Source files
------------

// File: rtl/score_bcd_converter.sv
// score_bcd_converter
// Sequential binary-to-BCD converter for the on-screen score. It uses a
// shift-and-add-3 (double-dabble) engine that consumes one input bit per clock.
// The four digit outputs are loaded together on the final iteration, so the
// renderer only ever sees complete results.
//
// Handshake: ready is high exactly while the FSM is IDLE. A conversion is
// accepted on a rising edge where ready=1 and start=1, and `in` is sampled on
// that same edge only. start is ignored while busy. done_tick pulses high for
// one cycle, together with the new digits, 14 edges after acceptance.
module score_bcd_converter #(
   parameter int MAX_VALUE = 9999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] in,
   output logic        ready,
   output logic        done_tick,
   output logic [3:0]  bcd3,
   output logic [3:0]  bcd2,
   output logic [3:0]  bcd1,
   output logic [3:0]  bcd0,
   output logic        dbg_state
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OP   = 1'b1
   } state_t;

   localparam logic [13:0] MAX_CLAMP = 14'(MAX_VALUE);
   localparam logic [3:0]  N_BITS    = 4'd14;

   state_t      r_state;
   state_t      w_state_next;
   logic        w_load;
   logic        w_last;

   logic [13:0] r_bin_work;
   logic [15:0] r_bcd_work;
   logic [3:0]  r_n;
   logic [3:0]  r_bcd3;
   logic [3:0]  r_bcd2;
   logic [3:0]  r_bcd1;
   logic [3:0]  r_bcd0;
   logic        r_done_tick;

   logic [13:0] w_in_clamped;
   logic [15:0] w_bcd_adj;
   logic [29:0] w_shifted;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and control strobes
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = S_OP;
            end
         end
         S_OP: begin
            if (r_n == 4'd1) begin
               w_last       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Clamp the incoming score so the result always fits in four digits
   always_comb begin
      w_in_clamped = (in > MAX_CLAMP) ? MAX_CLAMP : in;
   end

   // Add-3 adjust on every digit that is 5 or more, digits independent
   always_comb begin
      w_bcd_adj = r_bcd_work;
      for (int d = 0; d < 4; d++) begin
         if (r_bcd_work[d*4 +: 4] >= 4'd5) begin
            w_bcd_adj[d*4 +: 4] = r_bcd_work[d*4 +: 4] + 4'd3;
         end
      end
      w_shifted = {w_bcd_adj, r_bin_work} << 1;
   end

   // Working registers: load on accept, shift once per OP cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin_work <= '0;
         r_bcd_work <= '0;
         r_n        <= '0;
      end else if (w_load) begin
         r_bin_work <= w_in_clamped;
         r_bcd_work <= '0;
         r_n        <= N_BITS;
      end else if (r_state == S_OP) begin
         r_bin_work <= w_shifted[13:0];
         r_bcd_work <= w_shifted[29:14];
         r_n        <= r_n - 4'd1;
      end
   end

   // Output digits and completion pulse, updated only on the final iteration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bcd3      <= '0;
         r_bcd2      <= '0;
         r_bcd1      <= '0;
         r_bcd0      <= '0;
         r_done_tick <= 1'b0;
      end else begin
         r_done_tick <= 1'b0;
         if (w_last) begin
            r_bcd3      <= w_shifted[29:26];
            r_bcd2      <= w_shifted[25:22];
            r_bcd1      <= w_shifted[21:18];
            r_bcd0      <= w_shifted[17:14];
            r_done_tick <= 1'b1;
         end
      end
   end

   assign ready     = (r_state == S_IDLE);
   assign done_tick = r_done_tick;
   assign bcd3      = r_bcd3;
   assign bcd2      = r_bcd2;
   assign bcd1      = r_bcd1;
   assign bcd0      = r_bcd0;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Bench for score_bcd_converter: table-driven conversions, a scoreboard of
// expected digits, and hand-written busy, back-to-back and reset sequences.
module tb_score_bcd_converter;

   logic        clk;
   logic        clk_en;
   logic        reset;
   logic        start;
   logic [13:0] in;

   logic        ready,  done_tick,  dbg_state;
   logic [3:0]  bcd3,   bcd2,   bcd1,   bcd0;
   logic        ready_b, done_tick_b, dbg_state_b;
   logic [3:0]  bcd3_b, bcd2_b, bcd1_b, bcd0_b;

   int checks;
   int failures;
   int done_cnt;
   int cyc_cnt;
   int last_done_cyc;
   logic prev_done;

   logic [15:0] exp_q[$];

   typedef struct {
      logic [13:0] vin;
      logic [15:0] exp_d;
   } vec_t;

   vec_t vecs[10];

   score_bcd_converter #(.MAX_VALUE(9999)) dut (
      .clk(clk), .reset(reset), .start(start), .in(in),
      .ready(ready), .done_tick(done_tick),
      .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
      .dbg_state(dbg_state)
   );

   score_bcd_converter #(.MAX_VALUE(5000)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in(in),
      .ready(ready_b), .done_tick(done_tick_b),
      .bcd3(bcd3_b), .bcd2(bcd2_b), .bcd1(bcd1_b), .bcd0(bcd0_b),
      .dbg_state(dbg_state_b)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v, input int max_v);
      int c;
      c = (v > max_v) ? max_v : v;
      return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard push: record the expected result on each accepted start
   always @(posedge clk) begin
      cyc_cnt++;
      if (!reset && ready && start) exp_q.push_back(to_bcd(int'(in), 9999));
   end

   // A reset discards whatever was in flight
   always @(posedge reset) exp_q.delete();

   // Scoreboard pop and pulse-width check, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         if (done_tick) begin
            done_cnt++;
            last_done_cyc = cyc_cnt;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_done", 32'(done_tick), 32'(0));
            end else begin
               check("sb_digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, exp_q.pop_front()});
            end
            check("done_one_cycle", 32'(prev_done), 32'(0));
         end
         prev_done = done_tick;
      end else begin
         prev_done = 1'b0;
      end
   end

   // Driver: one conversion, checking latency, ready, digits and digit hold
   task automatic run_vec(input logic [13:0] v, input logic [15:0] exp_d,
                          input bit chk_hold, input logic [15:0] hold_d);
      int cyc;
      int w;
      w = 0;
      @(negedge clk);
      while (!ready && w < 30) begin
         @(negedge clk);
         w++;
      end
      check("ready_before_start", 32'(ready), 32'(1));
      start = 1'b1;
      in    = v;
      @(negedge clk);
      start = 1'b0;
      in    = 14'($urandom_range(0, 16383));
      cyc = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (done_tick) break;
         if (chk_hold) check("digits_hold", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, hold_d});
      end
      check("latency", 32'(cyc), 32'(14));
      check("ready_at_done", 32'(ready), 32'(1));
      check("digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, exp_d});
      check("digits_max5000", {16'h0, bcd3_b, bcd2_b, bcd1_b, bcd0_b},
            {16'h0, to_bcd(int'(v), 5000)});
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Watchdog
   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int d0;
      int t0, t1, t2;
      int w;
      checks = 0; failures = 0; done_cnt = 0; cyc_cnt = 0; last_done_cyc = 0;
      prev_done = 1'b0;
      clk_en = 1'b0; reset = 1'b0; start = 1'b0; in = '0;

      vecs[0] = '{14'd9990,  16'h9990};
      vecs[1] = '{14'd0,     16'h0000};
      vecs[2] = '{14'd1234,  16'h1234};
      vecs[3] = '{14'd16383, 16'h9999};
      vecs[4] = '{14'd10000, 16'h9999};
      vecs[5] = '{14'd9999,  16'h9999};
      vecs[6] = '{14'd6000,  16'h6000};
      vecs[7] = '{14'd1,     16'h0001};
      vecs[8] = '{14'd4095,  16'h4095};
      vecs[9] = '{14'd5000,  16'h5000};

      // Asynchronous reset with no clock running
      #1 reset = 1'b1;
      #3;
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_done", 32'(done_tick), 32'(0));
      check("rst_digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
      clk_en = 1'b1;
      idle_cycles(3);
      reset = 1'b0;
      idle_cycles(2);

      // Table-driven conversions
      for (int i = 0; i < 10; i++) begin
         d0 = done_cnt;
         run_vec(vecs[i].vin, vecs[i].exp_d, 1'b0, 16'h0);
         idle_cycles(1);
         check("one_done_per_conv", 32'(done_cnt - d0), 32'(1));
      end

      // Busy: start while converting 10 is ignored
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; in = 14'd10;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(3);
      start = 1'b1; in = 14'd20;
      @(negedge clk);
      start = 1'b0;
      idle_cycles(25);
      check("busy_digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0010);
      check("busy_one_done", 32'(done_cnt - d0), 32'(1));

      // Converting 20: digits keep showing 0010 until the end
      run_vec(14'd20, 16'h0020, 1'b1, 16'h0010);

      // Back-to-back with start held high
      @(negedge clk);
      start = 1'b1; in = 14'd40;
      d0 = done_cnt; w = 0;
      while (done_cnt == d0 && w < 40) begin @(negedge clk); w++; end
      t0 = last_done_cyc; d0 = done_cnt; w = 0;
      while (done_cnt == d0 && w < 40) begin @(negedge clk); w++; end
      t1 = last_done_cyc; d0 = done_cnt; w = 0;
      while (done_cnt == d0 && w < 40) begin @(negedge clk); w++; end
      t2 = last_done_cyc;
      check("b2b_interval_1", 32'(t1 - t0), 32'(15));
      check("b2b_interval_2", 32'(t2 - t1), 32'(15));
      check("b2b_digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0040);
      start = 1'b0;
      idle_cycles(20);
      check("b2b_drained", 32'(exp_q.size()), 32'(0));

      // Mid-operation reset
      @(negedge clk);
      start = 1'b1; in = 14'd9999;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'(1));
      check("midrst_done", 32'(done_tick), 32'(0));
      check("midrst_digits", {16'h0, bcd3, bcd2, bcd1, bcd0}, 32'h0);
      idle_cycles(2);
      reset = 1'b0;
      d0 = done_cnt;
      idle_cycles(20);
      check("midrst_no_done", 32'(done_cnt - d0), 32'(0));
      run_vec(14'd50, 16'h0050, 1'b0, 16'h0);

      idle_cycles(3);
      check("sb_empty", 32'(exp_q.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
